// File: rtl/ifu_fetch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_defs : shared FSM encodings, fault codes and constants for the IFU      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package ifu_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  FAULT_BUS      = 2'b10;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_fetch_ctrl_if : WBU PC handshake, AXI4-Lite read and IDU output bundle  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface ifu_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              wbu_valid;
  logic [ADDR_W-1:0] pc_in;
  logic              ifu_ready;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rready;
  logic              ifu_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic [1:0]        fault;
  logic              idu_ready;

  // master is the fetch controller, slave is its surroundings (WBU, bus, IDU)
  modport master (
    input  wbu_valid, pc_in, arready, rvalid, rdata, rresp, idu_ready,
    output ifu_ready, arvalid, araddr, rready, ifu_valid, inst, inst_pc, fault
  );

  modport slave (
    output wbu_valid, pc_in, arready, rvalid, rdata, rresp, idu_ready,
    input  ifu_ready, arvalid, araddr, rready, ifu_valid, inst, inst_pc, fault
  );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch_ctrl_perf_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_perf_cnt : delivered-instruction and bus-wait counters (IFU_PERF_EN)    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module ifu_perf_cnt (
  input  wire         clk,
  input  wire         rst,
  input  wire         fetch_inc,
  input  wire         stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_fetch_ctrl : single-outstanding instruction fetch over AXI4-Lite read;  |
// | optional perf counters under macro IFU_PERF_EN.            Rev 1.0          |
// +----------------------------------------------------------------------------+
module ifu_fetch_ctrl
  import ifu_defs::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = ifu_defs::NOP_INST
) (
  input  wire                clk,
  input  wire                rst,
  ifu_fetch_ctrl_if.master   bus,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
);

  state_t            state, state_nxt;
  logic              idle_st, addr_st, data_st, hold_st;
  logic              up_hs, misaligned;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_q;
  logic [1:0]        fault_q;

  assign misaligned = |bus.pc_in[1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idle_st   = 1'b0;
    addr_st   = 1'b0;
    data_st   = 1'b0;
    hold_st   = 1'b0;
    case (state)
      ST_IDLE: begin
        idle_st = 1'b1;
        if (bus.wbu_valid) state_nxt = misaligned ? ST_HOLD : ST_ADDR;
      end
      ST_ADDR: begin
        addr_st = 1'b1;
        if (bus.arready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        data_st = 1'b1;
        if (bus.rvalid) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        hold_st = 1'b1;
        if (bus.idu_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are masked by rst so an abort is visible in the reset cycle itself.
  assign bus.ifu_ready = idle_st & ~rst;
  assign bus.arvalid   = addr_st & ~rst;
  assign bus.rready    = data_st & ~rst;
  assign bus.ifu_valid = hold_st & ~rst;
  assign up_hs         = bus.ifu_ready & bus.wbu_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      fault_q <= FAULT_NONE;
    end else begin
      if (up_hs) begin
        pc_q <= bus.pc_in;
        if (misaligned) begin
          inst_q  <= NOP_INST;
          fault_q <= FAULT_MISALIGN;
        end
      end
      if (data_st && bus.rvalid) begin
        if (bus.rresp == RESP_OKAY) begin
          inst_q  <= bus.rdata;
          fault_q <= FAULT_NONE;
        end else begin
          inst_q  <= NOP_INST;
          fault_q <= FAULT_BUS;
        end
      end
    end
  end

  assign bus.araddr  = pc_q;
  assign bus.inst_pc = pc_q;
  assign bus.inst    = inst_q;
  assign bus.fault   = fault_q;

`ifdef IFU_PERF_EN
  ifu_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (bus.ifu_valid & bus.idu_ready),
    .stall_inc (addr_st | data_st),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
